// File: rtl/commit_sequencer.sv
// In-order retirement queue: records renamed instructions, marks writeback completion,
// retires the oldest done entry per cycle. Optional macro CSEQ_PERF_CNT_EN adds stall_cycles_o.
module commit_sequencer #(
  parameter  int DEPTH  = 32,
  parameter  int PIDX_W = 6,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              alloc_valid_i,
  input  logic              alloc_has_rd_i,
  input  logic [PIDX_W-1:0] alloc_pidx_i,
  output logic              alloc_ready_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic              br_flush_i,
  input  logic [TAG_W-1:0]  br_tag_i,
  output logic              commit_valid_o,
  output logic [PIDX_W-1:0] commit_pidx_o,
  output logic [TAG_W:0]    count_o,
  output logic              empty_o
`ifdef CSEQ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);

  logic [DEPTH-1:0]             r_valid, r_done, r_has_rd;
  logic [DEPTH-1:0][PIDX_W-1:0] r_pidx;
  logic [TAG_W:0]               r_head, r_tail;

  logic [TAG_W-1:0] w_hidx, w_tidx, w_br_off;
  logic [TAG_W:0]   w_flush_tail;
  logic [DEPTH-1:0] w_young;
  logic             w_full, w_empty, w_retire, w_alloc, w_wb;

  assign w_hidx  = r_head[TAG_W-1:0];
  assign w_tidx  = r_tail[TAG_W-1:0];
  assign w_empty = (r_head == r_tail);
  assign w_full  = (w_hidx == w_tidx) && (r_head[TAG_W] != r_tail[TAG_W]);

  // Age is measured as distance from head, so the flushed tail inherits the correct wrap bit.
  assign w_br_off     = br_tag_i - w_hidx;
  assign w_flush_tail = r_head + {1'b0, w_br_off} + (TAG_W+1)'(1);

  always_comb begin
    w_young = '0;
    for (int i = 0; i < DEPTH; i++)
      w_young[i] = (TAG_W'(i) - w_hidx) > w_br_off;
  end

  assign w_alloc  = alloc_valid_i && !w_full && !br_flush_i;
  assign w_wb     = wb_valid_i && r_valid[wb_tag_i] && !(br_flush_i && w_young[wb_tag_i]);
  assign w_retire = !w_empty && r_valid[w_hidx] && r_done[w_hidx];

  assign alloc_ready_o = !w_full;
  assign alloc_tag_o   = w_tidx;
  assign count_o       = r_tail - r_head;
  assign empty_o       = w_empty;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= '0;
      r_done   <= '0;
      r_has_rd <= '0;
      r_pidx   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
    end else begin
      if (w_wb) r_done[wb_tag_i] <= 1'b1;
      if (w_alloc) begin
        r_valid[w_tidx]  <= 1'b1;
        r_done[w_tidx]   <= 1'b0;
        r_has_rd[w_tidx] <= alloc_has_rd_i;
        r_pidx[w_tidx]   <= alloc_pidx_i;
        r_tail           <= r_tail + (TAG_W+1)'(1);
      end
      if (br_flush_i) begin
        r_valid <= r_valid & ~w_young;
        r_tail  <= w_flush_tail;
      end
      // Head is never younger than the branch, so retire composes with a flush.
      if (w_retire) begin
        r_valid[w_hidx] <= 1'b0;
        r_done[w_hidx]  <= 1'b0;
        r_head          <= r_head + (TAG_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_valid_o <= 1'b0;
      commit_pidx_o  <= '0;
    end else if (w_retire) begin
      commit_valid_o <= r_has_rd[w_hidx];
      commit_pidx_o  <= r_pidx[w_hidx];
    end else begin
      commit_valid_o <= 1'b0;
    end
  end

`ifdef CSEQ_PERF_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)
      r_stall <= '0;
    else if (!w_empty && !r_done[w_hidx] && (r_stall != 32'hFFFF_FFFF))
      r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles_o = r_stall;
`endif

endmodule

// File: doc/commit_sequencer.md
Name: commit_sequencer

Overview:
- In-order retirement controller that drives the physical-register commit port of the rename stage.
- Records every renamed instruction in program order, tracks completion reported by writeback, and retires the oldest completed entry each cycle.
- Emits one commit (physical rd index) per retired entry that has a destination, so rename can free the previous mapping.
- Also throttles allocation when full and truncates younger entries on branch flush.

Parameters:
- DEPTH, 32, number of in-flight entries; power of two, minimum 4.
- PIDX_W, 6, physical register index width.
- TAG_W, $clog2(DEPTH), entry tag width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i  in  1  renamed instruction present this cycle.
- alloc_has_rd_i  in  1  instruction writes a non-x0 destination.
- alloc_pidx_i  in  PIDX_W  physical rd index assigned by rename.
- alloc_ready_o  out  1  entry available; allocation accepted only when high.
- alloc_tag_o  out  TAG_W  tag given to the instruction accepted this cycle (current tail index).
- wb_valid_i  in  1  execution completed.
- wb_tag_i  in  TAG_W  tag of the completed instruction.
- br_flush_i  in  1  mispredict; discard all entries younger than br_tag_i.
- br_tag_i  in  TAG_W  tag of the mispredicted branch (kept).
- commit_valid_o  out  1  registered one-cycle commit pulse.
- commit_pidx_o  out  PIDX_W  physical index being committed.
- count_o  out  TAG_W+1  occupied entries, 0..DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage per entry: valid, done, has_rd, pidx.
- Pointers head and tail are TAG_W+1 bits; the MSB is the wrap bit.
  - Full: indices equal and wrap bits differ.
  - Empty: pointers fully equal.
- Reset (asynchronous, rst_ni low):
  - head = tail = 0; all valid/done cleared.
  - commit_valid_o = 0, commit_pidx_o = 0, count_o = 0, empty_o = 1, alloc_ready_o = 1.
  - Reset mid-operation discards all entries immediately; no commit pulse is generated.
- Allocate: when alloc_valid_i && alloc_ready_o && !br_flush_i:
  - write entry[tail] = {valid=1, done=0, has_rd, pidx};
  - tail += 1;
  - alloc_tag_o = tail index (combinational).
- alloc_ready_o = !full, combinational from registered pointers.
- Allocation attempted while full is dropped. The upstream stage must stall; no error signalling.
- Writeback: when wb_valid_i and entry[wb_tag_i].valid, set done = 1 at the edge.
  - Writeback to an invalid entry is ignored.
  - Writeback to an already-done entry is idempotent.
- Retire:
  - Each cycle, if not empty and entry[head].valid && entry[head].done: clear the entry and head += 1.
  - At the same edge, commit_valid_o <= has_rd and commit_pidx_o <= pidx.
  - Otherwise commit_valid_o <= 0 and commit_pidx_o holds its value.
  - At most one retire per cycle.
  - Latency: writeback in cycle N to the head entry gives commit_valid_o high in cycle N+2.
  - Entries with has_rd = 0 retire silently and consume the retire slot.
- Flush: br_flush_i:
  - clears valid on all entries strictly younger than br_tag_i;
  - sets tail = pointer of br_tag_i + 1, with the wrap bit derived relative to head;
  - takes priority over a same-cycle allocation, which is not accepted;
  - causes a same-cycle writeback to a flushed tag to be ignored;
  - lets a same-cycle retire of the head proceed. If head equals br_tag_i and retires, the queue becomes empty.
- Free-list recovery for flushed destinations is outside this block.
- count_o = tail − head, (TAG_W+1)-bit modular subtraction; registered pointers only.
- Simultaneous allocate + retire: count unchanged; full/empty evaluated from pointers after the edge.
- Wrap-around: pointers wrap modulo 2·DEPTH; tags are pointer LSBs.

Optional Feature:
- Macro: CSEQ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles_o, 32 bits.
  - It increments every cycle where the queue is non-empty and the head is not done.
  - It saturates at 0xFFFF_FFFF and is cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> commit_valid_o = 0, count_o = 0, empty_o = 1, alloc_ready_o = 1.
- Allocate pidx 32, 33, 34 (tags 0, 1, 2; has_rd = 1), writeback tags 2, 1, 0 in consecutive cycles -> commits 32, 33, 34 in consecutive cycles, first pulse 2 cycles after the tag-0 writeback; count_o returns to 0.
- Allocate 32 entries without writeback -> alloc_ready_o = 0 at count_o = 32; 33rd alloc dropped. Writeback tag 0 -> one commit, alloc_ready_o = 1, next alloc gets tag 0 (wrap).
- Allocate tags 0–5, br_flush_i with br_tag_i = 2 plus same-cycle alloc and writeback tag 4 -> count_o = 3, alloc not accepted, next alloc receives tag 3; writeback to flushed tag 4 has no effect.
- Allocate entry with has_rd = 0 then pidx 40, writeback both -> single commit pulse with commit_pidx_o = 40, one cycle after the silent retire.
- Assert rst_ni low while 4 entries are done and pending -> outputs return to reset values immediately, no commit pulse after release.
